demux14_stream: RTL and testbench

//  1-to-4 stream demultiplexer, the inverse of the team's 32-bit 4:1 mux.

---
 rtl/demux14_stream.sv | 121 ++++++++++++
 tb/tb_demux14_stream.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/demux14_stream.sv
// rtl/demux14_stream.sv - 1-to-4 stream demultiplexer with per-channel FIFOs
module demux14_stream #(
   parameter int W     = 32,
   parameter int DEPTH = 2,
   parameter int CW    = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [W-1:0]    in_data,
   input  logic            s1,
   input  logic            s0,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [4*W-1:0]  out_data,
   output logic [3:0]      out_valid,
   input  logic [3:0]      out_ready,
   output logic [4*CW-1:0] acc_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q  [4][DEPTH];
   logic [W-1:0]  mem_d  [4][DEPTH];
   logic [AW-1:0] wptr_q [4];
   logic [AW-1:0] wptr_d [4];
   logic [AW-1:0] rptr_q [4];
   logic [AW-1:0] rptr_d [4];
   logic [AW:0]   occ_q  [4];
   logic [AW:0]   occ_d  [4];
   logic [W-1:0]  head_q [4];
   logic [W-1:0]  head_d [4];
   logic [CW-1:0] cnt_q  [4];
   logic [CW-1:0] cnt_d  [4];

   logic [1:0] sel;
   logic [3:0] full;
   logic [3:0] push;
   logic [3:0] pop;

   assign sel      = {s1, s0};
   // in_ready looks only at the selected channel's fill level, never at in_valid
   assign in_ready = ~full[sel];

   // Per-channel full flags from the occupancy counters
   always_comb begin
      full = '0;
      for (int k = 0; k < 4; k++) begin
         full[k] = (occ_q[k] == (AW+1)'(DEPTH));
      end
   end

   // Handshake decode: one push at most (to the selected channel), independent pops
   always_comb begin
      push = '0;
      pop  = '0;
      for (int k = 0; k < 4; k++) begin
         push[k] = in_valid & in_ready & (sel == 2'(k));
         pop[k]  = out_valid[k] & out_ready[k];
      end
   end

   // Next-state for storage, pointers, occupancy, head register and counters
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      head_d = head_q;
      cnt_d  = cnt_q;
      for (int k = 0; k < 4; k++) begin
         if (push[k]) begin
            mem_d[k][wptr_q[k]] = in_data;
            wptr_d[k]           = wptr_q[k] + AW'(1);
            cnt_d[k]            = cnt_q[k] + CW'(1);
         end
         if (pop[k]) begin
            rptr_d[k] = rptr_q[k] + AW'(1);
         end
         occ_d[k] = occ_q[k] + (AW+1)'(push[k]) - (AW+1)'(pop[k]);
         // Head tracks the word that will sit at the read pointer; it keeps its
         // old value when the FIFO drains so out_data holds while invalid.
         if (occ_d[k] != '0) begin
            if ((occ_q[k] == '0) || (pop[k] && (occ_q[k] == (AW+1)'(1)))) begin
               head_d[k] = in_data;
            end else begin
               head_d[k] = mem_q[k][rptr_q[k] + AW'(pop[k])];
            end
         end
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < DEPTH; j++) begin
               mem_q[k][j] <= '0;
            end
            wptr_q[k] <= '0;
            rptr_q[k] <= '0;
            occ_q[k]  <= '0;
            head_q[k] <= '0;
            cnt_q[k]  <= '0;
         end
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         occ_q  <= occ_d;
         head_q <= head_d;
         cnt_q  <= cnt_d;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_out
      assign out_valid[g]          = (occ_q[g] != '0);
      assign out_data[g*W +: W]    = head_q[g];
      assign acc_cnt[g*CW +: CW]   = cnt_q[g];
   end

endmodule

// File: tb/tb_demux14_stream.sv
// tb/tb_demux14_stream.sv - self-checking bench for demux14_stream
module tb_demux14_stream;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  in_data;
   logic         s1, s0;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] out_data;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [63:0]  acc_cnt;

   int vectors = 0;
   int errors  = 0;

   demux14_stream #(.W(32), .DEPTH(2), .CW(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .s1        (s1),
      .s0        (s0),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_cnt   (acc_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: one queue per channel, a count per channel, last shown head
   logic [31:0] mq [4][$];
   logic [15:0] mcnt [4];
   logic [31:0] mhold [4];
   logic [31:0] rx3 [$];
   bit          rec3 = 0;

   task automatic model_clear();
      for (int k = 0; k < 4; k++) begin
         mq[k].delete();
         mcnt[k]  = '0;
         mhold[k] = '0;
      end
   endtask

   initial model_clear();

   always @(negedge rst_n) model_clear();

   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         logic [1:0] s;
         bit         acc;
         s   = {s1, s0};
         acc = in_valid && (mq[s].size() < 2);
         for (int k = 0; k < 4; k++) begin
            if (mq[k].size() > 0 && out_ready[k]) begin
               if (k == 3 && rec3) rx3.push_back(mq[k][0]);
               void'(mq[k].pop_front());
            end
         end
         if (acc) begin
            mq[s].push_back(in_data);
            mcnt[s] = mcnt[s] + 16'd1;
         end
         for (int k = 0; k < 4; k++) begin
            if (mq[k].size() > 0) mhold[k] = mq[k][0];
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every cycle against the model, away from the active edge
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("valid%0d", k), 64'(out_valid[k]), 64'(mq[k].size() > 0));
         chk($sformatf("data%0d", k), 64'(out_data[k*32 +: 32]), 64'(mhold[k]));
         chk($sformatf("cnt%0d", k), 64'(acc_cnt[k*16 +: 16]), 64'(mcnt[k]));
      end
      chk("in_ready", 64'(in_ready), 64'(mq[{s1, s0}].size() < 2));
   end

   task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d,
                       input logic [3:0] r);
      in_valid  = v;
      {s1, s0}  = s;
      in_data   = d;
      out_ready = r;
      @(posedge clk);
      #2;
   endtask

   initial begin
      in_valid  = 0;
      {s1, s0}  = 2'b00;
      in_data   = '0;
      out_ready = 4'b0000;
      rst_n     = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1;
      #1;
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_cnt", acc_cnt, 64'h0);
      chk("rst_ready", 64'(in_ready), 64'h1);
      @(posedge clk); #2;

      // Routing
      step(1, 2'b11, 32'h5, 4'hF);
      chk("rt_v3", 64'(out_valid), 64'h8);
      chk("rt_d3", 64'(out_data[96 +: 32]), 64'h5);
      step(1, 2'b01, 32'hA, 4'hF);
      chk("rt_v1", 64'(out_valid), 64'h2);
      chk("rt_d1", 64'(out_data[32 +: 32]), 64'hA);
      step(1, 2'b10, 32'hA, 4'hF);
      chk("rt_v2", 64'(out_valid), 64'h4);
      step(1, 2'b00, 32'h14, 4'hF);
      chk("rt_v0", 64'(out_valid), 64'h1);
      chk("rt_d0", 64'(out_data[0 +: 32]), 64'h14);
      step(0, 2'b00, 32'h0, 4'hF);
      chk("rt_cnt", acc_cnt, 64'h0001_0001_0001_0001);
      chk("rt_hold3", 64'(out_data[96 +: 32]), 64'h5);

      // Backpressure on ch2
      step(1, 2'b10, 32'h1, 4'b1011);
      step(1, 2'b10, 32'h2, 4'b1011);
      in_valid = 1; {s1, s0} = 2'b10; in_data = 32'h3;
      #1 chk("bp_full", 64'(in_ready), 64'h0);
      {s1, s0} = 2'b00; in_data = 32'h77;
      #1 chk("bp_other", 64'(in_ready), 64'h1);
      @(posedge clk); #2;
      chk("bp_ch0", 64'(out_data[0 +: 32]), 64'h77);
      step(1, 2'b10, 32'h3, 4'hF);
      chk("bp_h2a", 64'(out_data[64 +: 32]), 64'h2);
      step(1, 2'b10, 32'h3, 4'hF);
      chk("bp_h2b", 64'(out_data[64 +: 32]), 64'h3);
      step(0, 2'b00, 32'h0, 4'hF);
      chk("bp_cnt2", 64'(acc_cnt[32 +: 16]), 64'd4);

      // Full push+pop on ch1
      step(1, 2'b01, 32'h11, 4'b1101);
      step(1, 2'b01, 32'h12, 4'b1101);
      step(1, 2'b01, 32'h13, 4'hF);
      chk("fp_h1a", 64'(out_data[32 +: 32]), 64'h12);
      chk("fp_cnt1a", 64'(acc_cnt[16 +: 16]), 64'd3);
      step(1, 2'b01, 32'h13, 4'hF);
      chk("fp_h1b", 64'(out_data[32 +: 32]), 64'h13);
      chk("fp_cnt1b", 64'(acc_cnt[16 +: 16]), 64'd4);
      step(0, 2'b00, 32'h0, 4'hF);
      chk("fp_drain", 64'(out_valid), 64'h0);

      // Wrap: 10 words to ch3 with toggling ready
      begin
         int  i      = 0;
         int  budget = 0;
         bit  tog    = 0;
         bit  acc;
         rec3 = 1;
         while (i < 10 && budget < 100) begin
            in_valid  = 1; {s1, s0} = 2'b11; in_data = 32'(i);
            out_ready = {tog, 3'b111};
            #1 acc = in_ready;
            @(posedge clk); #2;
            if (acc) i++;
            tog = ~tog;
            budget++;
         end
         chk("wr_budget", 64'(budget < 100), 64'h1);
         step(0, 2'b00, 32'h0, 4'hF);
         step(0, 2'b00, 32'h0, 4'hF);
         step(0, 2'b00, 32'h0, 4'hF);
         rec3 = 0;
         chk("wr_cnt3", 64'(acc_cnt[48 +: 16]), 64'd11);
         chk("wr_rxn", 64'(rx3.size()), 64'd10);
         for (int j = 0; j < 10 && j < rx3.size(); j++) begin
            chk($sformatf("wr_rx%0d", j), 64'(rx3[j]), 64'(j));
         end
      end

      // Async reset mid-stream with two words parked in ch0
      step(1, 2'b00, 32'hAA, 4'b1110);
      step(1, 2'b00, 32'hBB, 4'b1110);
      step(0, 2'b00, 32'h0, 4'b1110);
      chk("ar_pre", 64'(out_valid), 64'h1);
      #1 rst_n = 0;
      #1;
      chk("ar_valid", 64'(out_valid), 64'h0);
      chk("ar_cnt", acc_cnt, 64'h0);
      chk("ar_data", 64'(out_data), 64'h0);
      @(posedge clk); #2 rst_n = 1;
      step(0, 2'b00, 32'h0, 4'hF);
      chk("ar_post", 64'(out_valid), 64'h0);
      chk("ar_post_cnt", acc_cnt, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
